// File: rtl/axil2wb_bridge_pkg.sv
// Shared constants for the AXI-Lite to Wishbone bridge: FSM encoding,
// Wishbone byte-select value and default parameter values.
package axil2wb_bridge_pkg;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WB_WR   = 2'd1;
   localparam logic [1:0] ST_WB_RD   = 2'd2;
   localparam logic [1:0] ST_RD_RESP = 2'd3;

   // Every access is a full 32-bit word
   localparam logic [3:0] WB_SEL_ALL = 4'hF;

   // Default parameter values for the bridge
   localparam logic [31:0] DEF_ADDR_BASE   = 32'h3000_0000;
   localparam logic [31:0] DEF_ERR_DATA    = 32'hDEAD_BEEF;
   localparam int unsigned DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/axil2wb_bridge_if.sv
// Signal bundle around the bridge: AXI-Lite (no B channel) on one side,
// Wishbone master on the other. The 'slave' modport is the bridge's view
// (AXI-Lite slave, Wishbone master); 'master' is the view of the
// surrounding system (AXI-Lite initiator plus Wishbone slave).
interface axil2wb_bridge_if #(
   parameter int unsigned pADDR_WIDTH = 32,
   parameter int unsigned pDATA_WIDTH = 32
);
   // AXI-Lite write address / data
   logic                   awvalid;
   logic [pADDR_WIDTH-1:0] awaddr;
   logic                   awready;
   logic                   wvalid;
   logic [pDATA_WIDTH-1:0] wdata;
   logic                   wready;
   // AXI-Lite read address / data
   logic                   arvalid;
   logic [pADDR_WIDTH-1:0] araddr;
   logic                   arready;
   logic                   rvalid;
   logic                   rready;
   logic [pDATA_WIDTH-1:0] rdata;
   // Wishbone master
   logic                   wbm_cyc_o;
   logic                   wbm_stb_o;
   logic                   wbm_we_o;
   logic [3:0]             wbm_sel_o;
   logic [pADDR_WIDTH-1:0] wbm_adr_o;
   logic [pDATA_WIDTH-1:0] wbm_dat_o;
   logic                   wbm_ack_i;
   logic [pDATA_WIDTH-1:0] wbm_dat_i;

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
      output awready, wready, arready, rvalid, rdata,
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      input  wbm_ack_i, wbm_dat_i
   );

   modport master (
      output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
      input  awready, wready, arready, rvalid, rdata,
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      output wbm_ack_i, wbm_dat_i
   );

endinterface

// File: rtl/axil2wb_arb.sv
// Two-way round-robin arbiter between the write and read request paths.
// The pointer only moves when both sides compete, so a lone requester never
// disturbs the fairness order.
module axil2wb_arb (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic req_wr_i,
   input  logic req_rd_i,
   output logic gnt_wr_o,
   output logic gnt_rd_o
);

   // ptr_q = 0: write side has priority, 1: read side has priority
   logic ptr_q;
   logic ptr_d;
   logic both;

   // Grant decode and pointer next state
   always_comb begin
      both     = en_i & req_wr_i & req_rd_i;
      gnt_wr_o = en_i & req_wr_i & (~req_rd_i | ~ptr_q);
      gnt_rd_o = en_i & req_rd_i & (~req_wr_i |  ptr_q);
      ptr_d    = both ? ~ptr_q : ptr_q;
   end

   // Pointer flop, write side first out of reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/axil2wb_bridge.sv
// AXI-Lite slave to Wishbone master bridge. One transaction in flight,
// writes are posted (no B channel), WB cycles are bounded by a timeout that
// sets a sticky error flag and returns ERR_DATA on reads.
module axil2wb_bridge
   import axil2wb_bridge_pkg::*;
#(
   parameter int unsigned                pADDR_WIDTH = 32,
   parameter int unsigned                pDATA_WIDTH = 32,
   parameter logic [pADDR_WIDTH-1:0]     ADDR_BASE   = DEF_ADDR_BASE,
   parameter int unsigned                TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter logic [pDATA_WIDTH-1:0]     ERR_DATA    = DEF_ERR_DATA
) (
   input  logic                  axis_clk,
   input  logic                  axis_rst_n,
   axil2wb_bridge_if.slave       bus,
   output logic                  err_o,
   input  logic                  err_clr_i
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [1:0]             state_q,  state_d;
   logic                   run_q;
   logic                   cyc_q,    cyc_d;
   logic                   we_q,     we_d;
   logic [pADDR_WIDTH-1:0] adr_q,    adr_d;
   logic [pDATA_WIDTH-1:0] dat_q,    dat_d;
   logic                   rvalid_q, rvalid_d;
   logic [pDATA_WIDTH-1:0] rdata_q,  rdata_d;
   logic                   err_q,    err_d;
   logic [CNT_W-1:0]       tmo_q,    tmo_d;

   logic arb_en;
   logic gnt_wr;
   logic gnt_rd;
   logic ack;
   logic tmo_hit;
   logic err_set;

   // Requests are only arbitrated in IDLE and never during/just out of reset,
   // so no ready can appear while the bridge is held in reset.
   assign arb_en = run_q & (state_q == ST_IDLE);

   axil2wb_arb u_arb (
      .clk_i    (axis_clk),
      .rst_ni   (axis_rst_n),
      .en_i     (arb_en),
      .req_wr_i (bus.awvalid & bus.wvalid),
      .req_rd_i (bus.arvalid),
      .gnt_wr_o (gnt_wr),
      .gnt_rd_o (gnt_rd)
   );

   // A late ack outside a cycle is ignored
   assign ack     = bus.wbm_ack_i & cyc_q;
   assign tmo_hit = cyc_q & ~bus.wbm_ack_i & (tmo_q == TMO_LAST);

   // Transaction sequencing and next-state for all bridge registers
   always_comb begin
      state_d  = state_q;
      cyc_d    = cyc_q;
      we_d     = we_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      tmo_d    = tmo_q;
      err_set  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (gnt_wr) begin
               cyc_d   = 1'b1;
               we_d    = 1'b1;
               adr_d   = ADDR_BASE + bus.awaddr;
               dat_d   = bus.wdata;
               tmo_d   = '0;
               state_d = ST_WB_WR;
            end else if (gnt_rd) begin
               cyc_d   = 1'b1;
               we_d    = 1'b0;
               adr_d   = ADDR_BASE + bus.araddr;
               tmo_d   = '0;
               state_d = ST_WB_RD;
            end
         end
         ST_WB_WR, ST_WB_RD: begin
            if (ack || tmo_hit) begin
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               err_set = ~ack;
               if (state_q == ST_WB_RD) begin
                  rdata_d  = ack ? bus.wbm_dat_i : ERR_DATA;
                  rvalid_d = 1'b1;
                  state_d  = ST_RD_RESP;
               end else begin
                  state_d  = ST_IDLE;
               end
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_RD_RESP: begin
            if (bus.rready) begin
               rvalid_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Timeout wins over a simultaneous clear
      err_d = err_set | (err_q & ~err_clr_i);
   end

   // Bridge state; reset aborts any Wishbone cycle at once
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q  <= ST_IDLE;
         run_q    <= 1'b0;
         cyc_q    <= 1'b0;
         we_q     <= 1'b0;
         adr_q    <= '0;
         dat_q    <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         run_q    <= 1'b1;
         cyc_q    <= cyc_d;
         we_q     <= we_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         tmo_q    <= tmo_d;
      end
   end

   assign bus.awready   = gnt_wr;
   assign bus.wready    = gnt_wr;
   assign bus.arready   = gnt_rd;
   assign bus.rvalid    = rvalid_q;
   assign bus.rdata     = rdata_q;
   assign bus.wbm_cyc_o = cyc_q;
   assign bus.wbm_stb_o = cyc_q;
   assign bus.wbm_we_o  = we_q;
   assign bus.wbm_sel_o = cyc_q ? WB_SEL_ALL : 4'h0;
   assign bus.wbm_adr_o = adr_q;
   assign bus.wbm_dat_o = dat_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_axil2wb_bridge.sv
// Directed bench for axil2wb_bridge with a Wishbone slave responder and a
// scoreboard of expected WB cycles and read responses.
module tb_axil2wb_bridge;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      int          len;   // expected cycle length, -1 = do not check
   } wb_exp_t;

   logic clk     = 1'b0;
   logic rst_n   = 1'b0;
   logic err_clr = 1'b0;
   logic err;

   int n_cmp = 0;
   int n_bad = 0;

   wb_exp_t     wb_q[$];
   logic [31:0] rd_q[$];

   int wb_wait   = 0;
   bit wb_noack  = 1'b0;
   int wb_cnt    = 0;

   axil2wb_bridge_if bus ();

   axil2wb_bridge dut (
      .axis_clk   (clk),
      .axis_rst_n (rst_n),
      .bus        (bus),
      .err_o      (err),
      .err_clr_i  (err_clr)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return bus.awready;
         1:       return bus.arready;
         2:       return bus.rvalid;
         default: return ~bus.wbm_cyc_o;
      endcase
   endfunction

   // Bounded wait; an expired bound shows up as a failed comparison
   task automatic wait_sig(input string tag, input int which, input int limit);
      int n = 0;
      while (sig(which) !== 1'b1 && n < limit) begin
         @(negedge clk); #1;
         n++;
      end
      chk(tag, {31'd0, sig(which)}, 32'd1);
   endtask

   task automatic finish_read(input int hold, input logic [31:0] exp_data);
      wait_sig("rvalid_seen", 2, 400);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk); #1;
         chk("rvalid_hold", bus.rvalid, 1);
         chk("rdata_hold", bus.rdata, exp_data);
      end
      bus.rready = 1'b1;
      @(posedge clk); #1;
      bus.rready = 1'b0;
      chk("rvalid_clr", bus.rvalid, 0);
   endtask

   function automatic wb_exp_t mk(input logic we, input logic [31:0] adr,
                                  input logic [31:0] dat, input int len);
      wb_exp_t e;
      e.we = we; e.adr = adr; e.dat = dat; e.len = len;
      return e;
   endfunction

   // Wishbone slave: ack after wb_wait wait states unless wb_noack
   initial begin
      bus.wbm_ack_i = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.wbm_cyc_o === 1'b1) begin
            wb_cnt++;
            bus.wbm_ack_i = !wb_noack && (wb_cnt > wb_wait);
         end else begin
            wb_cnt        = 0;
            bus.wbm_ack_i = 1'b0;
         end
      end
   end

   // Scoreboard monitor for WB cycles and read responses
   initial begin
      wb_exp_t cur;
      int      len_cnt = 0;
      logic    prev_cyc = 1'b0;
      logic    prev_rv  = 1'b0;
      cur = mk(0, 0, 0, -1);
      forever begin
         @(negedge clk);
         if (bus.wbm_cyc_o === 1'b1 && !prev_cyc) begin
            chk("wb_expected", {31'd0, wb_q.size() != 0}, 32'd1);
            if (wb_q.size() != 0) begin
               cur = wb_q.pop_front();
               chk("wb_we", bus.wbm_we_o, cur.we);
               chk("wb_adr", bus.wbm_adr_o, cur.adr);
               chk("wb_sel", bus.wbm_sel_o, 4'hF);
               chk("wb_stb", bus.wbm_stb_o, 1);
               if (cur.we) chk("wb_dat", bus.wbm_dat_o, cur.dat);
            end else begin
               cur = mk(0, 0, 0, -1);
            end
            len_cnt = 1;
         end else if (bus.wbm_cyc_o === 1'b1) begin
            len_cnt++;
            chk("wb_adr_stable", bus.wbm_adr_o, cur.adr);
         end else if (prev_cyc && cur.len >= 0) begin
            chk("wb_cyc_len", len_cnt, cur.len);
         end
         if (bus.rvalid === 1'b1 && !prev_rv) begin
            chk("rd_expected", {31'd0, rd_q.size() != 0}, 32'd1);
            if (rd_q.size() != 0) chk("rdata", bus.rdata, rd_q.pop_front());
         end
         prev_cyc = (bus.wbm_cyc_o === 1'b1);
         prev_rv  = (bus.rvalid === 1'b1);
      end
   end

   initial begin
      bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0;
      bus.arvalid = 0; bus.araddr = 0; bus.rready = 0; bus.wbm_dat_i = 0;

      // Reset with both request types already pending
      bus.awvalid = 1; bus.wvalid = 1; bus.awaddr = 32'h100; bus.wdata = 32'h1111_0001;
      bus.arvalid = 1; bus.araddr = 32'h200;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_cyc", bus.wbm_cyc_o, 0);
      chk("rst_stb", bus.wbm_stb_o, 0);
      chk("rst_we", bus.wbm_we_o, 0);
      chk("rst_sel", bus.wbm_sel_o, 0);
      chk("rst_adr", bus.wbm_adr_o, 0);
      chk("rst_rvalid", bus.rvalid, 0);
      chk("rst_awready", bus.awready, 0);
      chk("rst_arready", bus.arready, 0);
      chk("rst_err", err, 0);

      // Both pending out of reset: write first
      wb_wait = 0;
      bus.wbm_dat_i = 32'hCAFE_0002;
      wb_q.push_back(mk(1, 32'h3000_0100, 32'h1111_0001, 1));
      wb_q.push_back(mk(0, 32'h3000_0200, 0, 1));
      rd_q.push_back(32'hCAFE_0002);
      @(negedge clk); rst_n = 1;
      #1;
      wait_sig("arb1_awready", 0, 10);
      chk("arb1_wready", bus.wready, 1);
      chk("arb1_no_arready", bus.arready, 0);
      @(posedge clk); #1;
      bus.awvalid = 0; bus.wvalid = 0;
      wait_sig("arb1_arready", 1, 20);
      @(posedge clk); #1;
      bus.arvalid = 0;
      finish_read(0, 32'hCAFE_0002);

      // Both pending again: read first this time
      bus.wbm_dat_i = 32'hCAFE_0004;
      wb_q.push_back(mk(0, 32'h3000_0400, 0, 1));
      rd_q.push_back(32'hCAFE_0004);
      wb_q.push_back(mk(1, 32'h3000_0300, 32'h2222_0003, 1));
      @(negedge clk);
      bus.awvalid = 1; bus.wvalid = 1; bus.awaddr = 32'h300; bus.wdata = 32'h2222_0003;
      bus.arvalid = 1; bus.araddr = 32'h400;
      #1;
      wait_sig("arb2_arready", 1, 10);
      chk("arb2_no_awready", bus.awready, 0);
      @(posedge clk); #1;
      bus.arvalid = 0;
      finish_read(0, 32'hCAFE_0004);
      wait_sig("arb2_awready", 0, 20);
      @(posedge clk); #1;
      bus.awvalid = 0; bus.wvalid = 0;
      wait_sig("arb2_wr_done", 3, 20);

      // Write with two wait states
      wb_wait = 2;
      wb_q.push_back(mk(1, 32'h3000_0010, 32'hA5A5_0001, 3));
      @(negedge clk);
      bus.awvalid = 1; bus.wvalid = 1; bus.awaddr = 32'h10; bus.wdata = 32'hA5A5_0001;
      #1;
      wait_sig("wr_awready", 0, 10);
      chk("wr_wready", bus.wready, 1);
      @(posedge clk); #1;
      bus.awvalid = 0; bus.wvalid = 0;
      chk("wr_awready_pulse", bus.awready, 0);
      chk("wr_wready_pulse", bus.wready, 0);
      chk("wr_cyc_lat", bus.wbm_cyc_o, 1);
      chk("wr_we", bus.wbm_we_o, 1);
      wait_sig("wr_done", 3, 20);
      chk("wr_err", err, 0);

      // Zero-wait read, response held off for 5 cycles
      wb_wait = 0;
      bus.wbm_dat_i = 32'h1234_5678;
      wb_q.push_back(mk(0, 32'h3000_0004, 0, 1));
      rd_q.push_back(32'h1234_5678);
      @(negedge clk);
      bus.arvalid = 1; bus.araddr = 32'h4;
      #1;
      wait_sig("rd_arready", 1, 10);
      @(posedge clk); #1;
      bus.arvalid = 0;
      chk("rd_arready_pulse", bus.arready, 0);
      chk("rd_cyc_lat", bus.wbm_cyc_o, 1);
      chk("rd_rvalid_lat1", bus.rvalid, 0);
      @(posedge clk); #1;
      chk("rd_rvalid_lat2", bus.rvalid, 1);
      chk("rd_cyc_dropped", bus.wbm_cyc_o, 0);
      finish_read(5, 32'h1234_5678);

      // Read that is never acknowledged
      wb_noack = 1;
      bus.wbm_dat_i = 32'h0BAD_0BAD;
      wb_q.push_back(mk(0, 32'h3000_0008, 0, 255));
      rd_q.push_back(32'hDEAD_BEEF);
      @(negedge clk);
      bus.arvalid = 1; bus.araddr = 32'h8;
      #1;
      wait_sig("tmo_arready", 1, 10);
      @(posedge clk); #1;
      bus.arvalid = 0;
      chk("tmo_err_before", err, 0);
      finish_read(0, 32'hDEAD_BEEF);
      chk("tmo_err_set", err, 1);
      @(negedge clk); err_clr = 1;
      @(posedge clk); #1; err_clr = 0;
      chk("tmo_err_clr", err, 0);

      // Reset asserted in the middle of a read cycle
      wb_q.push_back(mk(0, 32'h3000_000C, 0, -1));
      @(negedge clk);
      bus.arvalid = 1; bus.araddr = 32'hC;
      #1;
      wait_sig("rst_rd_arready", 1, 10);
      @(posedge clk); #1;
      bus.arvalid = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("mid_cyc_before", bus.wbm_cyc_o, 1);
      #2; rst_n = 0;
      #1;
      chk("mid_rst_cyc", bus.wbm_cyc_o, 0);
      chk("mid_rst_stb", bus.wbm_stb_o, 0);
      chk("mid_rst_rvalid", bus.rvalid, 0);
      chk("mid_rst_sel", bus.wbm_sel_o, 0);
      @(negedge clk); rst_n = 1;
      wb_noack = 0;

      // Next read after reset completes normally
      bus.wbm_dat_i = 32'h5A5A_0005;
      wb_q.push_back(mk(0, 32'h3000_0014, 0, 1));
      rd_q.push_back(32'h5A5A_0005);
      @(negedge clk);
      bus.arvalid = 1; bus.araddr = 32'h14;
      #1;
      wait_sig("post_rst_arready", 1, 10);
      @(posedge clk); #1;
      bus.arvalid = 0;
      finish_read(0, 32'h5A5A_0005);

      repeat (3) @(negedge clk);
      chk("wb_q_drained", wb_q.size(), 0);
      chk("rd_q_drained", rd_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
